// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    localparam int         PS2_DATA_BITS  = 8;

    // PS/2 uses odd parity: data ones plus the parity bit must be odd.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the raw PS/2 pins and produces a one-cycle ps2_clk falling-edge strobe.
// Optional clock glitch filter is enabled with `define PS2_GLITCH_FILTER_EN.
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_fe,
    output logic o_data
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;
    logic       w_clk_cur;

    // Reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    logic [2:0] r_filt_sh;
    logic       r_clk_filt;
    logic [3:0] w_win;

    assign w_win = {r_filt_sh, r_clk_sync[1]};

    // Filtered clock moves only when four consecutive samples agree.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_filt_sh  <= 3'b111;
            r_clk_filt <= 1'b1;
        end else begin
            r_filt_sh <= w_win[2:0];
            if (&w_win)
                r_clk_filt <= 1'b1;
            else if (~|w_win)
                r_clk_filt <= 1'b0;
        end
    end

    assign w_clk_cur = r_clk_filt;
`else
    assign w_clk_cur = r_clk_sync[1];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_clk_prev <= 1'b1;
        else
            r_clk_prev <= w_clk_cur;
    end

    assign o_fe   = r_clk_prev & ~w_clk_cur;
    assign o_data = r_data_sync[1];

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard frame receiver: frame FSM, inter-edge timeout and E0/F0 prefix decoder.
// Build with `define PS2_GLITCH_FILTER_EN to insert the ps2_clk glitch filter.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       is_break,
    output logic       is_ext,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e r_state, w_state_nxt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_ext_flag;
    logic            r_brk_flag;

    logic w_fe, w_data, w_good, w_err, w_expire;

    ps2_sync_edge u_sync (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_fe       (w_fe),
        .o_data     (w_data)
    );

    assign w_expire = (r_state != IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

    // A falling edge takes priority over an expiring timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_err       = 1'b0;
        if (w_fe) begin
            case (r_state)
                IDLE:   if (w_data) w_err = 1'b1;
                        else        w_state_nxt = DATA;
                DATA:   if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) w_state_nxt = PARITY;
                PARITY: w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    if (w_data && odd_parity_ok(r_shift, r_par)) w_good = 1'b1;
                    else                                         w_err  = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end else if (w_expire) begin
            w_state_nxt = IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_to_cnt   <= '0;
            r_ext_flag <= 1'b0;
            r_brk_flag <= 1'b0;
            code       <= 8'h00;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            code_valid <= 1'b0;
            frame_err  <= w_err;

            if (w_fe || w_state_nxt == IDLE)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;

            if (w_fe && r_state == IDLE)
                r_bit_cnt <= '0;
            if (w_fe && r_state == DATA) begin
                r_shift   <= {w_data, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_fe && r_state == PARITY)
                r_par <= w_data;

            // Bad start bits leave pending prefixes alone; broken frames drop them.
            if (w_err && r_state != IDLE) begin
                r_ext_flag <= 1'b0;
                r_brk_flag <= 1'b0;
            end

            if (w_good) begin
                if (r_shift == PS2_EXT_PREFIX) begin
                    r_ext_flag <= 1'b1;
                end else if (r_shift == PS2_BRK_PREFIX) begin
                    r_brk_flag <= 1'b1;
                end else begin
                    code       <= r_shift;
                    is_ext     <= r_ext_flag;
                    is_break   <= r_brk_flag;
                    code_valid <= 1'b1;
                    r_ext_flag <= 1'b0;
                    r_brk_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed + randomized bench for ps2_scan_rx against a frame-level reference model.
module tb_ps2_scan_rx;

    localparam int TO   = 100;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       is_break, is_ext, code_valid, frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int cv_cnt = 0, er_cnt = 0, both_cnt = 0;
    int cv_cyc = 0, er_cyc = 0;
    int last_fall = 0;

    // reference state: held outputs and pending prefixes
    logic [7:0] m_code = 8'h00;
    logic       m_brk_out = 1'b0, m_ext_out = 1'b0;
    logic       m_brk = 1'b0, m_ext = 1'b0;

    ps2_scan_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .is_break   (is_break),
        .is_ext     (is_ext),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (code_valid) begin cv_cnt++; cv_cyc = cyc; end
        if (frame_err)  begin er_cnt++; er_cyc = cyc; end
        if (code_valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Send one frame, update the model from the protocol rules, compare.
    task automatic do_frame(input string tag, input logic [7:0] b, input bit bp, input bit bs);
        int cv0, er0, exp_cv, exp_er;
        cv0 = cv_cnt; er0 = er_cnt;
        exp_cv = 0; exp_er = 0;
        send_frame(b, bp, bs);
        if (bp || bs) begin
            exp_er = 1; m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            exp_cv = 1; m_code = b; m_ext_out = m_ext; m_brk_out = m_brk;
            m_ext = 0; m_brk = 0;
        end
        check({tag, ".valid_cnt"}, cv_cnt - cv0, exp_cv);
        check({tag, ".err_cnt"},   er_cnt - er0, exp_er);
        check({tag, ".code"},      code, m_code);
        check({tag, ".is_break"},  is_break, m_brk_out);
        check({tag, ".is_ext"},    is_ext, m_ext_out);
    endtask

    initial begin
        int cv0, er0, lat;
        logic [7:0] b;
        bit bp, bs;

        repeat (3) @(negedge clk);
        check("rst.code", code, 8'h00);
        check("rst.is_break", is_break, 1'b0);
        check("rst.is_ext", is_ext, 1'b0);
        check("rst.code_valid", code_valid, 1'b0);
        check("rst.frame_err", frame_err, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        do_frame("make_1c", 8'h1C, 0, 0);
        lat = cv_cyc - last_fall;
        check("latency_ok", (lat >= 3 && lat <= 4), 1'b1);

        do_frame("brk_f0", 8'hF0, 0, 0);
        do_frame("brk_1c", 8'h1C, 0, 0);
        do_frame("ext_e0", 8'hE0, 0, 0);
        do_frame("ext_f0", 8'hF0, 0, 0);
        do_frame("ext_75", 8'h75, 0, 0);
        do_frame("plain_75", 8'h75, 0, 0);
        do_frame("badpar_1c", 8'h1C, 1, 0);
        do_frame("pre_f0", 8'hF0, 0, 0);
        do_frame("badstop_1c", 8'h1C, 0, 1);
        do_frame("after_bad", 8'h1C, 0, 0);

        // lone clock pulse with data high: bad start bit
        cv0 = cv_cnt; er0 = er_cnt;
        ps2_bit(1'b1);
        repeat (HALF) @(negedge clk);
        check("badstart.err_cnt", er_cnt - er0, 1);
        check("badstart.valid_cnt", cv_cnt - cv0, 0);

        // pending break prefix, then a frame stalls after five data bits
        do_frame("to_f0", 8'hF0, 0, 0);
        cv0 = cv_cnt; er0 = er_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        repeat (TO + 30) @(negedge clk);
        check("timeout.err_cnt", er_cnt - er0, 1);
        check("timeout.valid_cnt", cv_cnt - cv0, 0);
        lat = er_cyc - last_fall;
        check("timeout.delay_ok", (lat >= TO + 2 && lat <= TO + 4), 1'b1);
        m_ext = 0; m_brk = 0;
        do_frame("after_to_29", 8'h29, 0, 0);

        // synchronous reset in the middle of a frame
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("midrst.code", code, 8'h00);
        check("midrst.is_break", is_break, 1'b0);
        check("midrst.is_ext", is_ext, 1'b0);
        check("midrst.code_valid", code_valid, 1'b0);
        check("midrst.frame_err", frame_err, 1'b0);
        m_code = 8'h00; m_brk_out = 0; m_ext_out = 0; m_brk = 0; m_ext = 0;
        repeat (5) @(negedge clk);
        do_frame("after_rst_1c", 8'h1C, 0, 0);

        // randomized traffic, prefixes weighted up
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom);
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 9) == 0);
            do_frame("rand", b, bp, bs);
        end

        check("no_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
